// File: rtl/am9513_legacy_bridge_if.sv
// rtl/am9513_legacy_bridge_if.sv - carbon_arch_pkg CSR address map and csr_if bus interface
package carbon_arch_pkg;
  localparam logic [15:0] LEGACY_PUSH_LO = 16'h0100;
  localparam logic [15:0] LEGACY_PUSH_HI = 16'h0104;
  localparam logic [15:0] LEGACY_POP_LO  = 16'h0108;
  localparam logic [15:0] LEGACY_POP_HI  = 16'h010C;
  localparam logic [15:0] LEGACY_OP      = 16'h0110;
  localparam logic [15:0] LEGACY_STATUS  = 16'h0114;
endpackage

interface csr_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_priv;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_priv, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
  modport slave (
    input  req_valid, req_write, req_priv, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/am9513_legacy_bridge.sv
// rtl/am9513_legacy_bridge.sv - byte-wide legacy port to 32-bit CSR bridge
// Optional busy polling before LEGACY_OP: AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
module am9513_legacy_bridge
  import carbon_arch_pkg::*;
#(
  parameter logic LEGACY_PRIV = 1'b0,
  parameter int   POLL_LIMIT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_req_valid,
  output logic       io_req_ready,
  input  logic       io_req_write,
  input  logic       io_req_cmd,
  input  logic [7:0] io_req_wdata,
  output logic       io_rsp_valid,
  input  logic       io_rsp_ready,
  output logic [7:0] io_rsp_rdata,
  csr_if.master      csr
);
  typedef enum logic [1:0] {IDLE, CSR_REQ, CSR_WAIT, IO_RSP} state_t;
  typedef enum logic [1:0] {K_PUSH, K_POP, K_CMD, K_STAT} kind_t;

  state_t      r_state, w_next;
  kind_t       r_kind;
  logic        r_step;
  logic [2:0]  r_wcnt, r_rcnt;
  logic [63:0] r_acc;
  logic [55:0] r_rbuf;
  logic [7:0]  r_rdata, r_op;
  logic        r_err;
  logic        w_accept, w_direct, w_seq_more;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_write;

`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] r_poll_cnt;
  logic          w_poll_last;
  assign w_poll_last = (r_poll_cnt == PW'(POLL_LIMIT - 1));
`endif

  assign w_accept = io_req_valid && rst_n && (r_state == IDLE);
  // Data bytes that need no CSR traffic are answered straight from the accumulator/buffer
  assign w_direct = !io_req_cmd && (io_req_write ? (r_wcnt != 3'd7) : (r_rcnt != 3'd0));

  always_comb begin
    w_seq_more = 1'b0;
    if (!csr.rsp_fault) begin
      case (r_kind)
        K_PUSH, K_POP: w_seq_more = !r_step;
`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
        K_CMD:         w_seq_more = !r_step && (!csr.rsp_rdata[0] || !w_poll_last);
`else
        K_CMD:         w_seq_more = !r_step;
`endif
        default:       w_seq_more = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_addr  = LEGACY_STATUS;
    w_wdata = 32'h0;
    w_write = 1'b0;
    case (r_kind)
      K_PUSH: begin
        w_write = 1'b1;
        w_addr  = r_step ? LEGACY_PUSH_HI : LEGACY_PUSH_LO;
        w_wdata = r_step ? r_acc[63:32] : r_acc[31:0];
      end
      K_POP: w_addr = r_step ? LEGACY_POP_HI : LEGACY_POP_LO;
      K_CMD: if (r_step) begin
        w_write = 1'b1;
        w_addr  = LEGACY_OP;
        w_wdata = {24'h0, r_op};
      end
      default: ;
    endcase
  end

  assign csr.req_addr  = w_addr;
  assign csr.req_wdata = w_wdata;
  assign csr.req_write = w_write;
  assign csr.req_priv  = LEGACY_PRIV;
  assign io_rsp_rdata  = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    io_req_ready  = 1'b0;
    io_rsp_valid  = 1'b0;
    csr.req_valid = 1'b0;
    csr.rsp_ready = 1'b0;
    case (r_state)
      IDLE: begin
        io_req_ready = rst_n;
        if (w_accept) w_next = w_direct ? IO_RSP : CSR_REQ;
      end
      CSR_REQ: begin
        csr.req_valid = 1'b1;
        if (csr.req_ready) w_next = CSR_WAIT;
      end
      CSR_WAIT: begin
        csr.rsp_ready = 1'b1;
        if (csr.rsp_valid) w_next = w_seq_more ? CSR_REQ : IO_RSP;
      end
      IO_RSP: begin
        io_rsp_valid = 1'b1;
        if (io_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind  <= K_PUSH;
      r_step  <= 1'b0;
      r_wcnt  <= 3'd0;
      r_rcnt  <= 3'd0;
      r_acc   <= 64'h0;
      r_rbuf  <= 56'h0;
      r_rdata <= 8'h00;
      r_op    <= 8'h00;
      r_err   <= 1'b0;
`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
      r_poll_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_step  <= 1'b0;
          r_rdata <= 8'h00;
          if (io_req_cmd && io_req_write) begin
            r_kind <= K_CMD;
            r_wcnt <= 3'd0;
            r_rcnt <= 3'd0;
            r_acc  <= 64'h0;
            r_rbuf <= 56'h0;
            r_op   <= io_req_wdata;
`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
            r_poll_cnt <= '0;
`else
            r_step <= 1'b1;
`endif
          end else if (io_req_cmd) begin
            r_kind <= K_STAT;
          end else if (io_req_write) begin
            r_kind <= K_PUSH;
            r_acc  <= {io_req_wdata, r_acc[63:8]};
            r_wcnt <= r_wcnt + 3'd1;
          end else begin
            r_kind <= K_POP;
            if (r_rcnt != 3'd0) begin
              r_rdata <= r_rbuf[7:0];
              r_rbuf  <= {8'h00, r_rbuf[55:8]};
              r_rcnt  <= r_rcnt - 3'd1;
            end
          end
        end
        CSR_WAIT: if (csr.rsp_valid) begin
          if (csr.rsp_fault) begin
            r_err   <= 1'b1;
            r_rdata <= 8'h00;
          end else begin
            case (r_kind)
              K_PUSH: r_step <= 1'b1;
              K_POP: if (!r_step) begin
                r_rbuf[31:0] <= csr.rsp_rdata;
                r_step       <= 1'b1;
              end else begin
                r_rdata <= r_rbuf[7:0];
                r_rbuf  <= {csr.rsp_rdata, r_rbuf[31:8]};
                r_rcnt  <= 3'd7;
              end
              K_STAT: begin
                r_rdata <= {csr.rsp_rdata[0], r_err, 2'b00, csr.rsp_rdata[7:4]};
                r_err   <= 1'b0;
              end
`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
              K_CMD: if (!r_step) begin
                if (!csr.rsp_rdata[0]) begin
                  r_step <= 1'b1;
                end else begin
                  r_poll_cnt <= r_poll_cnt + PW'(1);
                  if (w_poll_last) r_err <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_am9513_legacy_bridge.sv
// tb/tb_am9513_legacy_bridge.sv - directed self-checking bench for am9513_legacy_bridge
module tb_am9513_legacy_bridge;
  import carbon_arch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       io_req_valid, io_req_ready, io_req_write, io_req_cmd;
  logic [7:0] io_req_wdata;
  logic       io_rsp_valid, io_rsp_ready;
  logic [7:0] io_rsp_rdata;

  csr_if u_csr();

  am9513_legacy_bridge #(.LEGACY_PRIV(1'b1), .POLL_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_write(io_req_write), .io_req_cmd(io_req_cmd), .io_req_wdata(io_req_wdata),
    .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready), .io_rsp_rdata(io_rsp_rdata),
    .csr(u_csr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          phase;
  bit          s_hold, s_fault_once;
  logic [15:0] s_addr;
  logic [31:0] pop_lo, pop_hi, status_val;
  logic [31:0] stat_q[$];
  logic [15:0] log_addr[$];
  logic        log_wr[$];
  logic        log_priv[$];
  logic [31:0] log_data[$];

  logic [7:0]  rd_v;
  int          lat_v;
  logic [7:0]  exp_rd[8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
  localparam int OPI = 1;
`else
  localparam int OPI = 0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] a32(input logic [15:0] a);
    return {16'h0, a};
  endfunction

  function automatic logic [31:0] csr_resp(input logic [15:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == LEGACY_POP_LO) v = pop_lo;
    else if (a == LEGACY_POP_HI) v = pop_hi;
    else if (a == LEGACY_STATUS) v = (stat_q.size() > 0) ? stat_q.pop_front() : status_val;
    return v;
  endfunction

  // CSR slave: ready half a cycle after valid, one response the following cycle
  initial begin
    phase = 0;
    u_csr.req_ready = 1'b0;
    u_csr.rsp_valid = 1'b0;
    u_csr.rsp_rdata = 32'h0;
    u_csr.rsp_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        u_csr.req_ready = 1'b0;
        u_csr.rsp_valid = 1'b0;
        u_csr.rsp_fault = 1'b0;
      end else begin
        case (phase)
          0: if (u_csr.req_valid) begin
            log_addr.push_back(u_csr.req_addr);
            log_wr.push_back(u_csr.req_write);
            log_priv.push_back(u_csr.req_priv);
            log_data.push_back(u_csr.req_wdata);
            s_addr = u_csr.req_addr;
            u_csr.req_ready = 1'b1;
            phase = 1;
          end
          1: begin
            u_csr.req_ready = 1'b0;
            if (!s_hold) begin
              u_csr.rsp_rdata = csr_resp(s_addr);
              u_csr.rsp_fault = s_fault_once;
              s_fault_once = 1'b0;
              u_csr.rsp_valid = 1'b1;
              phase = 2;
            end
          end
          default: begin
            u_csr.rsp_valid = 1'b0;
            u_csr.rsp_fault = 1'b0;
            phase = 0;
          end
        endcase
      end
    end
  end

  task automatic clr_log();
    log_addr.delete();
    log_wr.delete();
    log_priv.delete();
    log_data.delete();
  endtask

  task automatic xfer(input logic wr, input logic cmd, input logic [7:0] wd);
    int n;
    @(negedge clk);
    io_req_valid = 1'b1;
    io_req_write = wr;
    io_req_cmd   = cmd;
    io_req_wdata = wd;
    n = 0;
    while (!io_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    io_req_valid = 1'b0;
    lat_v = 0;
    while (!io_rsp_valid && lat_v < 200) begin
      @(negedge clk);
      lat_v++;
    end
    check("rsp_timeout", {31'h0, lat_v < 200}, 32'h1);
    rd_v = io_rsp_rdata;
    @(negedge clk);
    check("rsp_hold", {23'h0, io_rsp_valid, io_rsp_rdata}, {23'h0, 1'b1, rd_v});
    io_rsp_ready = 1'b1;
    @(negedge clk);
    io_rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic stale;
    rst_n = 1'b0;
    io_req_valid = 1'b0; io_req_write = 1'b0; io_req_cmd = 1'b0; io_req_wdata = 8'h00;
    io_rsp_ready = 1'b0;
    s_hold = 1'b0; s_fault_once = 1'b0;
    pop_lo = 32'hDDCCBBAA; pop_hi = 32'h44332211; status_val = 32'h30;

    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", {31'h0, io_req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, io_rsp_valid}, 32'h0);
    check("rst_rsp_rdata", {24'h0, io_rsp_rdata}, 32'h0);
    check("rst_csr_req_valid", {31'h0, u_csr.req_valid}, 32'h0);
    check("rst_csr_rsp_ready", {31'h0, u_csr.rsp_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'h0, io_req_ready}, 32'h1);

    // eight data writes -> one push pair
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 1'b0, 8'(i + 1));
      check("w_rdata", {24'h0, rd_v}, 32'h0);
      if (i < 7) begin
        check("w_lat", lat_v, 0);
        check("w_no_csr", log_addr.size(), 0);
      end
    end
    check("push_cnt", log_addr.size(), 2);
    check("push_lo_addr", a32(log_addr[0]), a32(LEGACY_PUSH_LO));
    check("push_lo_data", log_data[0], 32'h04030201);
    check("push_hi_addr", a32(log_addr[1]), a32(LEGACY_PUSH_HI));
    check("push_hi_data", log_data[1], 32'h08070605);
    check("push_wr", {31'h0, log_wr[1]}, 32'h1);
    check("req_priv", {31'h0, log_priv[0]}, 32'h1);
    clr_log();

    // eight data reads -> one pop pair
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 1'b0, 8'h00);
      check("rd_byte", {24'h0, rd_v}, {24'h0, exp_rd[i]});
      if (i > 0) check("rd_lat", lat_v, 0);
    end
    check("pop_cnt", log_addr.size(), 2);
    check("pop_lo_addr", a32(log_addr[0]), a32(LEGACY_POP_LO));
    check("pop_hi_addr", a32(log_addr[1]), a32(LEGACY_POP_HI));
    check("pop_wr", {31'h0, log_wr[0]}, 32'h0);
    clr_log();

    // partial write discarded by command
    for (int i = 0; i < 3; i++) xfer(1'b1, 1'b0, 8'(8'h10 + i));
    xfer(1'b1, 1'b1, 8'h1A);
    check("op_cnt", log_addr.size(), OPI + 1);
    check("op_addr", a32(log_addr[OPI]), a32(LEGACY_OP));
    check("op_data", log_data[OPI], 32'h0000001A);
    clr_log();
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 1'b0, 8'(8'h21 + i));
      if (i == 6) check("post_cmd_no_csr", log_addr.size(), 0);
    end
    check("post_cmd_push_cnt", log_addr.size(), 2);
    check("post_cmd_push_lo", log_data[0], 32'h24232221);
    check("post_cmd_push_hi", log_data[1], 32'h28272625);
    clr_log();

    // read buffer discarded by command
    xfer(1'b0, 1'b0, 8'h00);
    check("rbuf_first", {24'h0, rd_v}, 32'hAA);
    xfer(1'b1, 1'b1, 8'h55);
    clr_log();
    xfer(1'b0, 1'b0, 8'h00);
    check("rbuf_refetch_byte", {24'h0, rd_v}, 32'hAA);
    check("rbuf_refetch_cnt", log_addr.size(), 2);
    clr_log();

    // status and sticky error
    status_val = 32'h31;
    xfer(1'b0, 1'b1, 8'h00);
    check("status_83", {24'h0, rd_v}, 32'h83);
    check("status_addr", a32(log_addr[0]), a32(LEGACY_STATUS));
    xfer(1'b1, 1'b1, 8'h00);
    clr_log();
    s_fault_once = 1'b1;
    xfer(1'b0, 1'b0, 8'h00);
    check("fault_rdata", {24'h0, rd_v}, 32'h0);
    check("fault_abort_cnt", log_addr.size(), 1);
    xfer(1'b0, 1'b1, 8'h00);
    check("status_err_set", {24'h0, rd_v}, 32'hC3);
    xfer(1'b0, 1'b1, 8'h00);
    check("status_err_clr", {24'h0, rd_v}, 32'h83);
    clr_log();
    status_val = 32'h30;
    for (int i = 0; i < 7; i++) xfer(1'b1, 1'b0, 8'h00);
    s_fault_once = 1'b1;
    xfer(1'b1, 1'b0, 8'h00);
    check("push_fault_abort", log_addr.size(), 1);
    xfer(1'b0, 1'b1, 8'h00);
    check("push_fault_status", {24'h0, rd_v}, 32'h43);
    clr_log();

    // reset while waiting for a CSR response
    status_val = 32'h31;
    s_hold = 1'b1;
    @(negedge clk);
    io_req_valid = 1'b1; io_req_write = 1'b0; io_req_cmd = 1'b1;
    @(negedge clk);
    io_req_valid = 1'b0;
    n = 0;
    while (!u_csr.rsp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_csr_wait", {31'h0, u_csr.rsp_ready}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'h0, u_csr.req_valid}, 32'h0);
    check("midrst_rsp_valid", {31'h0, io_rsp_valid}, 32'h0);
    s_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", {31'h0, io_req_ready}, 32'h1);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stale = stale | io_rsp_valid | u_csr.req_valid;
    end
    check("no_stale_rsp", {31'h0, stale}, 32'h0);
    xfer(1'b0, 1'b1, 8'h00);
    check("post_rst_status", {24'h0, rd_v}, 32'h83);
    clr_log();

`ifdef AM9513_LEGACY_BRIDGE_BUSY_WAIT_EN
    status_val = 32'h30;
    stat_q = '{32'h1, 32'h1, 32'h1, 32'h0};
    xfer(1'b1, 1'b1, 8'h3C);
    check("bw_cnt", log_addr.size(), 5);
    check("bw_poll4", a32(log_addr[3]), a32(LEGACY_STATUS));
    check("bw_op", a32(log_addr[4]), a32(LEGACY_OP));
    check("bw_op_data", log_data[4], 32'h3C);
    clr_log();
    stat_q = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    xfer(1'b1, 1'b1, 8'h3D);
    check("bw_stuck_cnt", log_addr.size(), 4);
    check("bw_stuck_last", a32(log_addr[3]), a32(LEGACY_STATUS));
    stat_q.delete();
    xfer(1'b0, 1'b1, 8'h00);
    check("bw_stuck_err", {24'h0, rd_v}, 32'h43);
    clr_log();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
